// File: rtl/bcd2bin_pkg.sv
// bcd2bin shared constants, state encoding and helpers.
// Four BCD digits in, one 14-bit unsigned integer out.
package bcd2bin_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int DIG_W      = 4;
    localparam int BCD_W      = BCD_DIGITS * DIG_W;
    localparam int BIN_W      = 14;
    localparam int SR_W       = 30;
    localparam int N_STEPS    = 14;
    localparam int CNT_W      = 4;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when every nibble of a packed BCD word is a legal digit (0..9).
    function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (d[i*DIG_W +: DIG_W] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble digit correction.
// A nibble of 8 or more after a right shift is reduced by 3.
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  logic [DIG_W-1:0] d_i,
    output logic [DIG_W-1:0] d_o
);

    logic ge8;

    // Bit 3 set is exactly "8 or more"; the subtract cannot underflow.
    assign ge8 = d_i[DIG_W-1];
    assign d_o = ge8 ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd2bin.sv
// bcd2bin: sequential BCD-to-binary converter, 14 shift/correct steps.
// Invalid digits short-circuit to an error result in one clock.
module bcd2bin
    import bcd2bin_pkg::*;
(
    input  logic             clkin,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       tho,
    input  logic [3:0]       hun,
    input  logic [3:0]       ten,
    input  logic [3:0]       uni,
    output logic [BIN_W-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [BCD_W-1:0] digits;
    logic [SR_W-1:0]  sh;
    logic [SR_W-1:0]  corr;
    logic             start;
    logic             dig_ok;

    assign digits = {tho, hun, ten, uni};
    assign dig_ok = bcd_ok(digits);

    // One right shift: the BCD field LSB drops into the binary field MSB.
    assign sh = {1'b0, sr_q[SR_W-1:1]};

    // Binary field passes through; each BCD nibble gets corrected.
    assign corr[BIN_W-1:0] = sh[BIN_W-1:0];

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (sh[BIN_W + g*DIG_W +: DIG_W]),
            .d_o (corr[BIN_W + g*DIG_W +: DIG_W])
        );
    end

    // Requests are only sampled while not converting.
    assign start = enable && (state_q != CONV);

    // Next-state, datapath and output register updates.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (dig_ok) begin
                        sr_d    = {digits, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = CONV;
                    end else begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            CONV: begin
                sr_d  = corr;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_STEP) begin
                    data_d  = corr[BIN_W-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data = data_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: table vectors, random requests against a decimal model,
// and hand-written sequences for overlap, reset and back-to-back.
module tb_bcd2bin;

    logic        clkin;
    logic        reset;
    logic        enable;
    logic [3:0]  tho, hun, ten, uni;
    logic [13:0] data;
    logic        busy, done, err;

    int n_checks;
    int n_fail;

    bcd2bin dut (
        .clkin  (clkin),
        .reset  (reset),
        .enable (enable),
        .tho    (tho),
        .hun    (hun),
        .ten    (ten),
        .uni    (uni),
        .data   (data),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    typedef struct {
        logic [3:0] d3, d2, d1, d0;
        int         exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    function automatic logic model_bad(input int a, b, c, d);
        return (a > 9) || (b > 9) || (c > 9) || (d > 9);
    endfunction

    function automatic int model_val(input int a, b, c, d);
        return a * 1000 + b * 100 + c * 10 + d;
    endfunction

    // Issue one single-cycle request and check its full outcome.
    task automatic run_req(input logic [3:0] a, b, c, d,
                           input int exp_data, input logic exp_err,
                           input string nm);
        logic [13:0] prev;
        int          lat;
        logic        stable;
        tho = a; hun = b; ten = c; uni = d;
        enable = 1'b1;
        step();
        enable = 1'b0;
        if (exp_err) begin
            chk({nm, "_done"}, done, 1);
            chk({nm, "_err"}, err, 1);
            chk({nm, "_data"}, data, 0);
            chk({nm, "_busy"}, busy, 0);
        end else begin
            chk({nm, "_busy_on"}, busy, 1);
            chk({nm, "_done_off"}, done, 0);
            prev   = data;
            stable = 1'b1;
            lat    = 0;
            for (int i = 1; i <= 40; i++) begin
                step();
                if (done) begin
                    lat = i;
                    break;
                end
                if (data !== prev) stable = 1'b0;
            end
            chk({nm, "_latency"}, lat, 14);
            chk({nm, "_data"}, data, exp_data);
            chk({nm, "_err"}, err, 0);
            chk({nm, "_busy_off"}, busy, 0);
            chk({nm, "_hold"}, stable, 1);
        end
    endtask

    initial begin
        logic [3:0] r3, r2, r1, r0;
        int         lat;
        logic       saw;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        enable   = 1'b0;
        tho = 0; hun = 0; ten = 0; uni = 0;

        vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0};
        vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0};
        vecs[3] = '{4'd0, 4'hA, 4'd0, 4'd5, 0, 1'b1};
        vecs[4] = '{4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0};
        vecs[5] = '{4'hF, 4'd0, 4'd0, 4'd0, 0, 1'b1};
        vecs[6] = '{4'd0, 4'd0, 4'd0, 4'd9, 9, 1'b0};
        vecs[7] = '{4'd8, 4'd1, 4'd9, 4'd2, 8192, 1'b0};

        repeat (3) @(posedge clkin);
        #1;
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clkin);
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0,
                    vecs[i].exp_data, vecs[i].exp_err,
                    $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 25; i++) begin
            r3 = 4'($urandom_range(0, 11));
            r2 = 4'($urandom_range(0, 9));
            r1 = 4'($urandom_range(0, 10));
            r0 = 4'($urandom_range(0, 9));
            run_req(r3, r2, r1, r0,
                    model_bad(r3, r2, r1, r0) ? 0 : model_val(r3, r2, r1, r0),
                    model_bad(r3, r2, r1, r0), $sformatf("rnd%0d", i));
        end

        // Enable pulse during CONV must be ignored.
        tho = 5; hun = 0; ten = 0; uni = 0;
        enable = 1'b1;
        step();
        enable = 1'b0;
        lat = 0;
        repeat (4) step();
        tho = 0; hun = 0; ten = 0; uni = 1;
        enable = 1'b1;
        step();
        enable = 1'b0;
        for (int i = 6; i <= 40; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("ovl_latency", lat, 14);
        chk("ovl_data", data, 5000);
        step();
        chk("ovl_no_restart_busy", busy, 0);
        chk("ovl_hold_done", done, 1);

        // Reset in the middle of a conversion.
        tho = 9; hun = 9; ten = 9; uni = 9;
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (6) step();
        reset = 1'b0;
        #1;
        chk("mrst_data", data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", err, 0);
        @(negedge clkin);
        reset = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            step();
            if (done || busy) saw = 1'b1;
        end
        chk("mrst_no_done", saw, 0);
        run_req(9, 9, 9, 9, 9999, 1'b0, "post_rst");

        // Back-to-back with enable held high.
        tho = 0; hun = 0; ten = 4; uni = 2;
        enable = 1'b1;
        step();
        chk("b2b_busy1", busy, 1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("b2b_lat1", lat, 14);
        chk("b2b_data1", data, 42);
        tho = 7; hun = 3; ten = 5; uni = 1;
        step();
        chk("b2b_done_pulse", done, 0);
        chk("b2b_busy2", busy, 1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
        enable = 1'b0;
        chk("b2b_lat2", lat, 14);
        chk("b2b_data2", data, 7351);
        step();
        chk("b2b_hold_done", done, 1);
        chk("b2b_hold_data", data, 7351);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd2bin.md
# bcd2bin

Sequential BCD-to-binary converter. It takes four BCD digits (thousands, hundreds, tens, units) and produces the equivalent 14-bit unsigned integer using reverse double-dabble: shift right, then subtract 3 from every digit that is 8 or more. It sits on the input side of the display/keypad path, wherever operator-entered decimal setpoints must become binary values for the energy-supervision datapath.

## Interface
- Parameters: none. Widths are fixed by package constants.
- clkin  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start request, sampled only in IDLE or DONE.
- tho  in  4  thousands digit.
- hun  in  4  hundreds digit.
- ten  in  4  tens digit.
- uni  in  4  units digit.
- data  out  14  converted binary value, registered.
- busy  out  1  conversion in progress.
- done  out  1  result (or error) valid. Level signal.
- err  out  1  the last request held a digit greater than 9.

## Operation
- States:
  - IDLE: after reset.
  - CONV: 14 shift/correct steps.
  - DONE: result held.
- IDLE or DONE with enable=1 on an edge (the load edge):
  - If every digit is 9 or less:
    - Load sr[29:0] = {tho,hun,ten,uni,14'b0}.
    - Set cnt=0, busy=1, done=0, err=0, go to CONV.
  - If any digit is greater than 9:
    - Set data=0, err=1, done=1, busy=0, go to DONE. No conversion is run.
- CONV, every edge, in one cycle:
  - Shift sr right by 1. The LSB of the BCD field enters the MSB of the binary field.
  - In each of the four BCD nibbles of the shifted value, subtract 3 if the nibble is 8 or more.
  - Increment cnt.
- On the edge that completes step 14 (cnt=13 before the edge):
  - data <= binary field of the corrected value.
  - done=1, busy=0, go to DONE.
- enable during CONV is ignored. No queuing, no restart.
- DONE holds data, done and err until the next accepted enable or a reset.
  - The load edge of a new request clears done, and clears err for a valid request.
- data changes only at completion or on an error load. Intermediate shift values are never visible on data.
- Arithmetic:
  - The nibble subtract is 4-bit and cannot underflow, because it only applies when the nibble is 8 or more.
  - The maximum input, 9999, gives 0x270F and fits in 14 bits. The BCD field is zero after step 14.

## Timing
- Reset (asynchronous assert, clkin-synchronous release): data=0, busy=0, done=0, err=0, state IDLE, sr=0, cnt=0.
- Valid request: busy rises on the load edge E0. done rises and busy falls on edge E0+14. Latency is 14 clocks from load to result.
- Invalid request: done=1 and err=1 from edge E0. Latency is 1 clock.
- Back-to-back: with enable held high, a new conversion loads on the first edge in DONE. done is therefore high for exactly 1 cycle between conversions.
- Reset asserted mid-CONV: everything returns to reset values immediately. The partial result is discarded and no done pulse is produced.
- Digits must be stable only at the load edge. They are captured into sr, so later changes have no effect.

## Structure
- Package bcd2bin_pkg holds:
  - BCD_DIGITS=4, BIN_W=14, SR_W=30, N_STEPS=14.
  - The state enum {IDLE, CONV, DONE}.
  - The counter width (4 bits).
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, output = in-3 if in is 8 or more, else in. Instantiated 4 times on the shifted register.
- The top level contains the FSM, the shift register, the counter and the output registers.

## Test plan
- Digits 1,2,3,4, one-cycle enable -> busy high for 14 cycles, then data=1234 (0x4D2), done=1, err=0.
- Digits 9,9,9,9 -> data=9999 (0x270F). Digits 0,0,0,0 -> data=0 with done after 14 clocks.
- Digits 0,0xA,0,5 -> next edge err=1, done=1, data=0, busy never asserted. A following valid request clears err.
- Request 5000; pulse enable at cycle 5 of CONV with digits 0,0,0,1 -> result 5000, second request ignored.
- Assert reset at cycle 7 of a 9999 conversion -> all outputs 0 immediately, state IDLE, no done. The next request converts correctly.
- enable held high with digits changing every conversion (0042, then 7351) -> each result correct, done low during each CONV, high 1 cycle between conversions.
